// File: rtl/des_key_schedule.sv
// rtl/des_key_schedule.sv - sequential DES round-key generator, one 48-bit key per clock
module des_key_schedule (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic        i_decrypt,
    input  logic [63:0] i_key,
    output logic        o_busy,
    output logic        o_rd_key_valid,
    output logic [47:0] o_rd_key,
    output logic [3:0]  o_round,
    output logic        o_done
);

    localparam logic [6:0] PC1 [56] = '{
        7'd57, 7'd49, 7'd41, 7'd33, 7'd25, 7'd17, 7'd9,
        7'd1,  7'd58, 7'd50, 7'd42, 7'd34, 7'd26, 7'd18,
        7'd10, 7'd2,  7'd59, 7'd51, 7'd43, 7'd35, 7'd27,
        7'd19, 7'd11, 7'd3,  7'd60, 7'd52, 7'd44, 7'd36,
        7'd63, 7'd55, 7'd47, 7'd39, 7'd31, 7'd23, 7'd15,
        7'd7,  7'd62, 7'd54, 7'd46, 7'd38, 7'd30, 7'd22,
        7'd14, 7'd6,  7'd61, 7'd53, 7'd45, 7'd37, 7'd29,
        7'd21, 7'd13, 7'd5,  7'd28, 7'd20, 7'd12, 7'd4
    };

    localparam logic [5:0] PC2 [48] = '{
        6'd14, 6'd17, 6'd11, 6'd24, 6'd1,  6'd5,
        6'd3,  6'd28, 6'd15, 6'd6,  6'd21, 6'd10,
        6'd23, 6'd19, 6'd12, 6'd4,  6'd26, 6'd8,
        6'd16, 6'd7,  6'd27, 6'd20, 6'd13, 6'd2,
        6'd41, 6'd52, 6'd31, 6'd37, 6'd47, 6'd55,
        6'd30, 6'd40, 6'd51, 6'd45, 6'd33, 6'd48,
        6'd44, 6'd49, 6'd39, 6'd56, 6'd34, 6'd53,
        6'd46, 6'd42, 6'd50, 6'd36, 6'd29, 6'd32
    };

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state;
    logic [27:0] c;
    logic [27:0] d;
    logic [3:0]  cnt;
    logic        dec;

    // Table entries are 1-indexed FIPS bit numbers; bit 1 is the vector MSB.
    function automatic logic [55:0] pc1_perm(input logic [63:0] k);
        logic [55:0] r;
        r = '0;
        for (logic [5:0] j = 6'd0; j < 6'd56; j = j + 6'd1)
            r[6'd55 - j] = k[6'(7'd64 - PC1[j])];
        return r;
    endfunction

    function automatic logic [47:0] pc2_perm(input logic [55:0] p);
        logic [47:0] r;
        r = '0;
        for (logic [5:0] j = 6'd0; j < 6'd48; j = j + 6'd1)
            r[6'd47 - j] = p[6'd56 - PC2[j]];
        return r;
    endfunction

    function automatic logic [27:0] rol(input logic [27:0] x, input logic two);
        return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
    endfunction

    function automatic logic [27:0] ror(input logic [27:0] x, input logic two);
        return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
    endfunction

    function automatic logic shift_two(input logic [4:0] r);
        return !(r == 5'd1 || r == 5'd2 || r == 5'd9 || r == 5'd16);
    endfunction

    logic [55:0] pc1_key;
    logic        enc_two;
    logic        dec_two;

    assign pc1_key = pc1_perm(i_key);
    // Encrypt steps toward round cnt+2; decrypt undoes the shift that produced round 16-cnt.
    assign enc_two = shift_two({1'b0, cnt} + 5'd2);
    assign dec_two = shift_two(5'd16 - {1'b0, cnt});

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state          <= IDLE;
            c              <= '0;
            d              <= '0;
            cnt            <= '0;
            dec            <= 1'b0;
            o_busy         <= 1'b0;
            o_rd_key_valid <= 1'b0;
            o_rd_key       <= '0;
            o_round        <= '0;
            o_done         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    o_rd_key_valid <= 1'b0;
                    o_done         <= 1'b0;
                    o_busy         <= 1'b0;
                    if (i_start) begin
                        dec    <= i_decrypt;
                        cnt    <= '0;
                        o_busy <= 1'b1;
                        state  <= RUN;
                        // C16/D16 equal C0/D0, so decrypt starts from the unrotated halves.
                        if (i_decrypt) begin
                            c <= pc1_key[55:28];
                            d <= pc1_key[27:0];
                        end else begin
                            c <= rol(pc1_key[55:28], 1'b0);
                            d <= rol(pc1_key[27:0], 1'b0);
                        end
                    end
                end
                RUN: begin
                    o_busy         <= 1'b1;
                    o_rd_key_valid <= 1'b1;
                    o_rd_key       <= pc2_perm({c, d});
                    o_round        <= cnt;
                    o_done         <= (cnt == 4'd15);
                    cnt            <= cnt + 4'd1;
                    if (dec) begin
                        c <= ror(c, dec_two);
                        d <= ror(d, dec_two);
                    end else begin
                        c <= rol(c, enc_two);
                        d <= rol(d, enc_two);
                    end
                    if (cnt == 4'd15)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_des_key_schedule.sv
// tb/tb_des_key_schedule.sv - directed and model-based checks for des_key_schedule
module tb_des_key_schedule;

    logic        clk;
    logic        i_rst;
    logic        i_start;
    logic        i_decrypt;
    logic [63:0] i_key;
    logic        o_busy;
    logic        o_rd_key_valid;
    logic [47:0] o_rd_key;
    logic [3:0]  o_round;
    logic        o_done;

    des_key_schedule dut (
        .i_clk          (clk),
        .i_rst          (i_rst),
        .i_start        (i_start),
        .i_decrypt      (i_decrypt),
        .i_key          (i_key),
        .o_busy         (o_busy),
        .o_rd_key_valid (o_rd_key_valid),
        .o_rd_key       (o_rd_key),
        .o_round        (o_round),
        .o_done         (o_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [63:0] FIPS_KEY = 64'h133457799BBCDFF1;

    int pc1_t [56] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18, 10,2,59,51,43,35,27,
                       19,11,3,60,52,44,36, 63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                       14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
    int pc2_t [48] = '{14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8, 16,7,27,20,13,2,
                       41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};

    logic [47:0] fips_k [16] = '{
        48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
        48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
        48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
        48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
    };

    typedef struct {
        logic [63:0] key;
        logic        dec;
        logic [47:0] first;
        logic [47:0] last;
    } vec_t;

    vec_t vecs [6];

    logic [47:0] mdl     [16];
    logic [47:0] cap_key [16];
    logic [47:0] enc_key [16];
    int cap_n, cap_done_n, cap_done_idx, cap_round_err;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Forward-only reference: iterate C/D from round 0 with the standard left shifts.
    task automatic build_model(input logic [63:0] key);
        logic [55:0] p;
        logic [63:0] t64;
        logic [55:0] t56;
        logic [27:0] cc, dd;
        logic [47:0] k;
        int n;
        p = '0;
        for (int j = 0; j < 56; j++) begin
            t64 = key >> (64 - pc1_t[j]);
            p = {p[54:0], t64[0]};
        end
        cc = p[55:28];
        dd = p[27:0];
        for (int r = 1; r <= 16; r++) begin
            n = (r == 1 || r == 2 || r == 9 || r == 16) ? 1 : 2;
            for (int s = 0; s < n; s++) begin
                cc = {cc[26:0], cc[27]};
                dd = {dd[26:0], dd[27]};
            end
            k = '0;
            for (int j = 0; j < 48; j++) begin
                t56 = {cc, dd} >> (56 - pc2_t[j]);
                k = {k[46:0], t56[0]};
            end
            mdl[r-1] = k;
        end
    endtask

    task automatic run_key(input logic [63:0] key, input logic dec, input int poke_at);
        cap_n = 0;
        cap_done_n = 0;
        cap_done_idx = -1;
        cap_round_err = 0;
        i_key = key;
        i_decrypt = dec;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        i_key = ~key;
        i_decrypt = ~dec;
        for (int cyc = 0; cyc < 24; cyc++) begin
            tick();
            i_start = 1'b0;
            if (o_rd_key_valid) begin
                if (cap_n < 16) begin
                    cap_key[cap_n] = o_rd_key;
                    if (o_round != 4'(cap_n)) cap_round_err++;
                end
                if (o_done) begin
                    cap_done_n++;
                    cap_done_idx = cap_n;
                end
                cap_n++;
                if (cap_n == poke_at) begin
                    i_start = 1'b1;
                    i_key = 64'h0123456789ABCDEF;
                    i_decrypt = ~dec;
                end
            end else if (cap_n > 0) begin
                break;
            end
        end
        i_start = 1'b0;
    endtask

    task automatic verify(input string name, input logic dec, input logic [47:0] first,
                          input logic [47:0] last);
        int bad;
        bad = 0;
        check({name, "_count"}, 64'(cap_n), 64'd16);
        check({name, "_round_idx"}, 64'(cap_round_err), 64'd0);
        check({name, "_done_count"}, 64'(cap_done_n), 64'd1);
        check({name, "_done_pos"}, 64'(cap_done_idx), 64'd15);
        check({name, "_busy_after"}, {63'd0, o_busy}, 64'd0);
        check({name, "_first"}, {16'd0, cap_key[0]}, {16'd0, first});
        check({name, "_last"}, {16'd0, cap_key[15]}, {16'd0, last});
        for (int i = 0; i < 16; i++)
            if (cap_key[i] !== mdl[dec ? 15 - i : i]) bad++;
        check({name, "_model"}, 64'(bad), 64'd0);
    endtask

    initial begin
        int bad;
        int waited;
        vecs[0] = '{FIPS_KEY,              1'b0, 48'h1B02EFFC7072, 48'hCB3D8B0E17F5};
        vecs[1] = '{FIPS_KEY,              1'b1, 48'hCB3D8B0E17F5, 48'h1B02EFFC7072};
        vecs[2] = '{64'h0000000000000000, 1'b0, 48'h000000000000, 48'h000000000000};
        vecs[3] = '{64'hFFFFFFFFFFFFFFFF, 1'b1, 48'hFFFFFFFFFFFF, 48'hFFFFFFFFFFFF};
        vecs[4] = '{64'h0101010101010101, 1'b0, 48'h000000000000, 48'h000000000000};
        vecs[5] = '{64'hFEFEFEFEFEFEFEFE, 1'b1, 48'hFFFFFFFFFFFF, 48'hFFFFFFFFFFFF};

        i_rst = 1'b1;
        i_start = 1'b0;
        i_decrypt = 1'b0;
        i_key = '0;
        tick();
        tick();
        check("reset_outputs", {55'd0, o_busy, o_rd_key_valid, o_done, o_round},
              64'd0);
        check("reset_key", {16'd0, o_rd_key}, 64'd0);
        i_rst = 1'b0;
        tick();

        for (int v = 0; v < 6; v++) begin
            build_model(vecs[v].key);
            run_key(vecs[v].key, vecs[v].dec, -1);
            verify($sformatf("vec%0d", v), vecs[v].dec, vecs[v].first, vecs[v].last);
        end

        // Whole FIPS schedule, with a start pulse during RUN that must be ignored.
        build_model(FIPS_KEY);
        run_key(FIPS_KEY, 1'b0, 5);
        bad = 0;
        for (int i = 0; i < 16; i++) if (cap_key[i] !== fips_k[i]) bad++;
        check("fips_enc_all_with_poke", 64'(bad), 64'd0);
        verify("poke_enc", 1'b0, fips_k[0], fips_k[15]);
        run_key(FIPS_KEY, 1'b1, 9);
        bad = 0;
        for (int i = 0; i < 16; i++) if (cap_key[i] !== fips_k[15 - i]) bad++;
        check("fips_dec_all_with_poke", 64'(bad), 64'd0);
        tick();

        // Exact latency, idle hold, and back-to-back acceptance in the first IDLE cycle.
        i_key = FIPS_KEY;
        i_decrypt = 1'b0;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        check("lat_after_start", {62'd0, o_busy, o_rd_key_valid}, 64'd2);
        bad = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (!o_rd_key_valid || !o_busy || o_round != 4'(i) || o_done != (i == 15)) bad++;
        end
        check("lat_16_valid", 64'(bad), 64'd0);
        tick();
        check("lat_idle_flags", {61'd0, o_busy, o_rd_key_valid, o_done}, 64'd0);
        check("idle_key_hold", {16'd0, o_rd_key}, {16'd0, fips_k[15]});
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        bad = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (!o_rd_key_valid || o_round != 4'(i)) bad++;
        end
        check("b2b_first_run", 64'(bad), 64'd0);
        i_start = 1'b1;
        i_decrypt = 1'b1;
        tick();
        i_start = 1'b0;
        check("b2b_busy_held", {62'd0, o_busy, o_rd_key_valid}, 64'd2);
        tick();
        check("b2b_second_first", {11'd0, o_rd_key_valid, o_round, o_rd_key},
              {11'd0, 1'b1, 4'd0, fips_k[15]});
        waited = 0;
        while (o_rd_key_valid && waited < 20) begin
            tick();
            waited++;
        end
        check("b2b_drain", {63'd0, o_rd_key_valid}, 64'd0);

        // Asynchronous reset in the middle of a run.
        i_key = FIPS_KEY;
        i_decrypt = 1'b0;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        waited = 0;
        while (!(o_rd_key_valid && o_round == 4'd7) && waited < 20) begin
            tick();
            waited++;
        end
        check("rst_reached_round7", {11'd0, o_rd_key_valid, o_round, o_rd_key},
              {11'd0, 1'b1, 4'd7, fips_k[7]});
        #1 i_rst = 1'b1;
        #1;
        check("rst_async_flags", {55'd0, o_busy, o_rd_key_valid, o_done, o_round}, 64'd0);
        check("rst_async_key", {16'd0, o_rd_key}, 64'd0);
        tick();
        i_rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (o_rd_key_valid || o_done || o_busy) bad++;
        end
        check("rst_no_resume", 64'(bad), 64'd0);
        run_key(FIPS_KEY, 1'b0, -1);
        verify("rst_restart", 1'b0, fips_k[0], fips_k[15]);

        // Random keys in both modes against the forward model.
        for (int n = 0; n < 1000; n++) begin
            logic [63:0] rk;
            rk = {$urandom, $urandom};
            build_model(rk);
            run_key(rk, 1'b0, -1);
            verify($sformatf("rand%0d_enc", n), 1'b0, mdl[0], mdl[15]);
            for (int i = 0; i < 16; i++) enc_key[i] = cap_key[i];
            run_key(rk, 1'b1, -1);
            verify($sformatf("rand%0d_dec", n), 1'b1, mdl[15], mdl[0]);
            bad = 0;
            for (int i = 0; i < 16; i++) if (cap_key[i] !== enc_key[15 - i]) bad++;
            check($sformatf("rand%0d_reverse", n), 64'(bad), 64'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
